// File: rtl/cia_sdr.sv
// CIA serial data register and shifter: timer-A-clocked output shifting, CNT-clocked input.
// The input shifter is built only when CIA_SDR_RX_EN is defined; the default build is output-only.
module cia_sdr (
  input  logic       clk,
  input  logic       res,
  input  logic       phi2_dn,
  input  logic       sdr_w,
  input  logic [7:0] data,
  input  logic       spmode,
  input  logic       ta_int,
  input  logic       cnt_in,
  input  logic       sp_in,
  output logic [7:0] regs,
  output logic       sp_out,
  output logic       sp_oe,
  output logic       cnt_out,
  output logic       cnt_oe,
  output logic       sp_int
);

  logic [7:0] r_sdr;
  logic [7:0] r_shift;
  logic       r_pending;
  logic       r_busy;
  logic [4:0] r_halfcnt;
  logic       r_spmode_prev;
  logic       r_cnt_out;
  logic       r_sp_out;
  logic       r_sp_int;
  logic       w_mode_chg;

`ifdef CIA_SDR_RX_EN
  logic [2:0] r_bitcnt;
  logic       r_cnt_prev;
  logic       w_cnt_rise;
  logic       w_rx_done;
  logic [7:0] w_rx_byte;

  assign w_cnt_rise = ~r_cnt_prev & cnt_in;
  assign w_rx_done  = w_cnt_rise & (r_bitcnt == 3'd7);
  assign w_rx_byte  = {r_shift[6:0], sp_in};
`else
  logic w_unused_rx;

  assign w_unused_rx = cnt_in ^ sp_in;
`endif

  assign w_mode_chg = (spmode != r_spmode_prev);

  assign regs    = r_sdr;
  assign sp_out  = r_sp_out;
  assign sp_oe   = spmode;
  assign cnt_out = r_cnt_out;
  assign cnt_oe  = spmode;
  assign sp_int  = r_sp_int;

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_sdr         <= 8'h00;
      r_shift       <= 8'h00;
      r_pending     <= 1'b0;
      r_busy        <= 1'b0;
      r_halfcnt     <= 5'd0;
      r_spmode_prev <= 1'b0;
      r_cnt_out     <= 1'b1;
      r_sp_out      <= 1'b1;
      r_sp_int      <= 1'b0;
`ifdef CIA_SDR_RX_EN
      r_bitcnt      <= 3'd0;
      r_cnt_prev    <= 1'b1;
`endif
    end else if (phi2_dn) begin
      r_sp_int      <= 1'b0;
      r_spmode_prev <= spmode;
`ifdef CIA_SDR_RX_EN
      r_cnt_prev    <= cnt_in;
`endif
      if (w_mode_chg) begin
        // Direction change kills any transfer in flight; sdr and SP level survive.
        r_busy    <= 1'b0;
        r_pending <= 1'b0;
        r_halfcnt <= 5'd0;
        r_cnt_out <= 1'b1;
`ifdef CIA_SDR_RX_EN
        r_bitcnt  <= 3'd0;
`endif
        if (sdr_w) begin
          r_sdr <= data;
        end
      end else if (spmode) begin
        if (!r_busy && r_pending) begin
          // Idle load takes a whole PHI2 cycle, so a coincident underflow is dropped.
          r_shift   <= r_sdr;
          r_pending <= 1'b0;
          r_busy    <= 1'b1;
          r_halfcnt <= 5'd0;
        end else if (r_busy && ta_int) begin
          r_halfcnt <= r_halfcnt + 5'd1;
          r_cnt_out <= ~r_cnt_out;
          if (r_cnt_out) begin
            r_sp_out <= r_shift[7];
            r_shift  <= {r_shift[6:0], 1'b0};
          end else if (r_halfcnt == 5'd15) begin
            r_sp_int <= 1'b1;
            r_busy   <= 1'b0;
          end
        end
        // A write in the same cycle as a load or completion leaves pending set for the next load.
        if (sdr_w) begin
          r_sdr     <= data;
          r_pending <= 1'b1;
        end
      end else begin
`ifdef CIA_SDR_RX_EN
        if (w_cnt_rise) begin
          r_shift  <= w_rx_byte;
          r_bitcnt <= r_bitcnt + 3'd1;
        end
        if (w_rx_done) begin
          r_sdr    <= w_rx_byte;
          r_sp_int <= 1'b1;
        end else if (sdr_w) begin
          r_sdr <= data;
        end
`else
        if (sdr_w) begin
          r_sdr <= data;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_cia_sdr.sv
// Directed self-checking bench for cia_sdr; input-mode expectations follow CIA_SDR_RX_EN.
module tb_cia_sdr;

  logic       clk;
  logic       res;
  logic       phi2_dn;
  logic       sdr_w;
  logic [7:0] data;
  logic       spmode;
  logic       ta_int;
  logic       cnt_in;
  logic       sp_in;
  logic [7:0] regs;
  logic       sp_out;
  logic       sp_oe;
  logic       cnt_out;
  logic       cnt_oe;
  logic       sp_int;

  int          n_cmp;
  int          n_err;
  int          n_spint;
  int          n_fall;
  int          n_consec;
  logic        prev_cnt;
  logic        prev_spint;
  logic [15:0] rx_bits;

  cia_sdr dut (
    .clk     (clk),
    .res     (res),
    .phi2_dn (phi2_dn),
    .sdr_w   (sdr_w),
    .data    (data),
    .spmode  (spmode),
    .ta_int  (ta_int),
    .cnt_in  (cnt_in),
    .sp_in   (sp_in),
    .regs    (regs),
    .sp_out  (sp_out),
    .sp_oe   (sp_oe),
    .cnt_out (cnt_out),
    .cnt_oe  (cnt_oe),
    .sp_int  (sp_int)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // One PHI2 cycle: strobe on the first clk, idle on the second, outputs sampled #1 after edges.
  task automatic phi(input logic ta, input logic w, input logic [7:0] d);
    ta_int  = ta;
    sdr_w   = w;
    data    = d;
    phi2_dn = 1'b1;
    @(posedge clk);
    #1;
    phi2_dn = 1'b0;
    ta_int  = 1'b0;
    sdr_w   = 1'b0;
    @(posedge clk);
    #1;
    if (sp_int) n_spint++;
    if (sp_int && prev_spint) n_consec++;
    if (prev_cnt && !cnt_out) n_fall++;
    if (!prev_cnt && cnt_out) rx_bits = {rx_bits[14:0], sp_out};
    prev_cnt   = cnt_out;
    prev_spint = sp_int;
  endtask

  task automatic clr_stats();
    n_spint = 0;
    n_fall  = 0;
    rx_bits = 16'h0000;
  endtask

  initial begin
    logic [7:0] pat;
    int         spi0;
    n_cmp = 0; n_err = 0; n_consec = 0;
    res = 1'b0; phi2_dn = 1'b0; sdr_w = 1'b0; data = 8'h00;
    spmode = 1'b1; ta_int = 1'b0; cnt_in = 1'b1; sp_in = 1'b1;
    prev_cnt = 1'b1; prev_spint = 1'b0;
    clr_stats();

    #1 res = 1'b1;
    #3;
    check("rst_regs", {8'h00, regs}, 16'h0000);
    check("rst_cnt", {15'd0, cnt_out}, 16'd1);
    check("rst_sp", {15'd0, sp_out}, 16'd1);
    check("rst_int", {15'd0, sp_int}, 16'd0);
    check("oe_out", {14'd0, sp_oe, cnt_oe}, 16'd3);
    @(negedge clk);
    res = 1'b0;
    repeat (3) phi(1'b0, 1'b0, 8'h00);

    // Output 0xA5, one underflow every fourth PHI2 cycle
    clr_stats();
    pat = 8'hA5;
    phi(1'b0, 1'b1, 8'hA5);
    check("wr_regs", {8'h00, regs}, 16'h00A5);
    for (int u = 0; u < 16; u++) begin
      repeat (3) phi(1'b0, 1'b0, 8'h00);
      phi(1'b1, 1'b0, 8'h00);
      check("a5_cnt", {15'd0, cnt_out}, {15'd0, u[0]});
      check("a5_sp", {15'd0, sp_out}, {15'd0, pat[7 - u / 2]});
      check("a5_int", {15'd0, sp_int}, (u == 15) ? 16'd1 : 16'd0);
    end
    repeat (4) phi(1'b0, 1'b0, 8'h00);
    check("a5_bits", rx_bits, 16'h00A5);
    check("a5_falls", n_fall[15:0], 16'd8);
    check("a5_nint", n_spint[15:0], 16'd1);
    check("a5_sphold", {15'd0, sp_out}, 16'd1);
    check("a5_cntidle", {15'd0, cnt_out}, 16'd1);

    // Back-to-back 0x3C then 0xC3 written mid-transfer
    clr_stats();
    phi(1'b0, 1'b1, 8'h3C);
    for (int k = 0; k < 32; k++) begin
      phi(1'b0, (k == 4), 8'hC3);
      phi(1'b1, 1'b0, 8'h00);
    end
    repeat (4) phi(1'b0, 1'b0, 8'h00);
    check("b2b_bits", rx_bits, 16'h3CC3);
    check("b2b_falls", n_fall[15:0], 16'd16);
    check("b2b_nint", n_spint[15:0], 16'd2);
    check("b2b_regs", {8'h00, regs}, 16'h00C3);

    // Input mode: 0x96 MSB first on 8 CNT rising edges
    spmode = 1'b0;
    phi(1'b0, 1'b0, 8'h00);
    phi(1'b0, 1'b0, 8'h00);
    check("in_oe", {14'd0, sp_oe, cnt_oe}, 16'd0);
    clr_stats();
    pat = 8'h96;
    for (int b = 7; b >= 0; b--) begin
      sp_in  = pat[b];
      cnt_in = 1'b0;
      phi(1'b0, 1'b0, 8'h00);
      cnt_in = 1'b1;
      phi(1'b0, 1'b0, 8'h00);
    end
`ifdef CIA_SDR_RX_EN
    check("in_regs", {8'h00, regs}, 16'h0096);
    check("in_int", {15'd0, sp_int}, 16'd1);
    check("in_nint", n_spint[15:0], 16'd1);
`else
    check("in_regs", {8'h00, regs}, 16'h00C3);
    check("in_int", {15'd0, sp_int}, 16'd0);
    check("in_nint", n_spint[15:0], 16'd0);
`endif
    sp_in  = 1'b0;
    cnt_in = 1'b0;
    phi(1'b0, 1'b0, 8'h00);
    cnt_in = 1'b1;
    phi(1'b0, 1'b0, 8'h00);
    check("in_9th", {15'd0, sp_int}, 16'd0);
    phi(1'b0, 1'b1, 8'h5A);
    check("in_wr", {8'h00, regs}, 16'h005A);
    check("in_cntpin", {15'd0, cnt_out}, 16'd1);

    // Mode switch after 5 underflows aborts the transfer
    spmode = 1'b1;
    phi(1'b0, 1'b0, 8'h00);
    phi(1'b0, 1'b1, 8'h81);
    for (int k = 0; k < 5; k++) begin
      phi(1'b0, 1'b0, 8'h00);
      phi(1'b1, 1'b0, 8'h00);
    end
    check("ms_cnt5", {15'd0, cnt_out}, 16'd0);
    check("ms_sp5", {15'd0, sp_out}, 16'd0);
    spi0 = n_spint;
    spmode = 1'b0;
    phi(1'b0, 1'b0, 8'h00);
    check("ms_cnt", {15'd0, cnt_out}, 16'd1);
    check("ms_int", {15'd0, sp_int}, 16'd0);
    check("ms_sphold", {15'd0, sp_out}, 16'd0);
    spmode = 1'b1;
    phi(1'b0, 1'b0, 8'h00);
    repeat (20) phi(1'b1, 1'b0, 8'h00);
    check("ms_noint", n_spint[15:0], spi0[15:0]);
    check("ms_idle", {15'd0, cnt_out}, 16'd1);
    clr_stats();
    phi(1'b0, 1'b1, 8'h80);
    for (int k = 0; k < 16; k++) begin
      phi(1'b0, 1'b0, 8'h00);
      phi(1'b1, 1'b0, 8'h00);
    end
    repeat (3) phi(1'b0, 1'b0, 8'h00);
    check("ms_bits", rx_bits, 16'h0080);
    check("ms_nint", n_spint[15:0], 16'd1);
    check("consec_int", n_consec[15:0], 16'd0);

    // Asynchronous reset in the middle of a transfer
    phi(1'b0, 1'b1, 8'h42);
    phi(1'b0, 1'b0, 8'h00);
    phi(1'b1, 1'b0, 8'h00);
    check("pre_rst_cnt", {15'd0, cnt_out}, 16'd0);
    check("pre_rst_sp", {15'd0, sp_out}, 16'd0);
    #2 res = 1'b1;
    #1;
    check("mid_rst_cnt", {15'd0, cnt_out}, 16'd1);
    check("mid_rst_sp", {15'd0, sp_out}, 16'd1);
    check("mid_rst_regs", {8'h00, regs}, 16'h0000);
    check("mid_rst_int", {15'd0, sp_int}, 16'd0);
    @(negedge clk);
    res = 1'b0;
    repeat (2) phi(1'b0, 1'b0, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
